// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the TX-fifo write-port arbiter.
// Holds the arbiter state encoding and the round-robin pointer increment.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // The wrap is an explicit compare so non-power-of-two requester counts work.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: finds the first set request bit at or after ptr.
// Rotates the request vector so ptr lands on bit 0, finds the lowest set bit, then rotates back.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    localparam logic [IW:0] N_W = (IW + 1)'(N);

    logic [N-1:0]  rotated;
    logic [IW-1:0] first;
    logic [IW:0]   sum_raw;

    // ptr is always below N, so the doubled vector shifted right holds the rotation.
    assign rotated = N'({req, req} >> ptr);

    always_comb begin
        first = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                first = IW'(j);
            end
        end
    end

    assign sum_raw = {1'b0, ptr} + {1'b0, first};
    assign index   = IW'((sum_raw >= N_W) ? (sum_raw - N_W) : sum_raw);
    assign found   = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the UART TX fifo push port between N_REQ byte producers.
// One grant per arbitration, bursts capped at MAX_BURST words, back-pressured by fifo_full.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_push,
    output logic [WIDTH-1:0]           fifo_data,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    // Handshake: a word of requester i moves on the rising edge where
    // req_valid[i] && req_ready[i]; ready depends only on the current grant and
    // fifo_full, never on valid, and a granted requester keeps valid high until it
    // finishes or deliberately withdraws (dropping valid ends its grant).

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t        state, state_d;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]  grant_d;
    logic [CNT_W-1:0]  beat_cnt, beat_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;

    logic [WIDTH-1:0]  data_arr [N_REQ];
    logic              g_valid;
    logic              g_last;
    logic [WIDTH-1:0]  g_data;
    logic              transfer;
    logic              rel;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    rr_priority_pick #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    assign g_valid  = req_valid[grant_id];
    assign g_last   = req_last[grant_id];
    assign g_data   = data_arr[grant_id];
    assign transfer = (state == GRANT) && g_valid && !fifo_full;

    // Withdrawal releases even while the fifo is full; a last word on the final beat is one release.
    assign rel = (state == GRANT) &&
                 (!g_valid || (transfer && (g_last || (beat_cnt == LAST_BEAT))));

    always_comb begin
        req_ready = '0;
        fifo_push = 1'b0;
        fifo_data = '0;
        if (!reset && (state == GRANT)) begin
            req_ready[grant_id] = !fifo_full;
            fifo_push           = transfer;
            if (transfer) begin
                fifo_data = g_data;
            end
        end
    end

    assign busy = (state == GRANT) && !reset;

    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        grant_d  = grant_id;
        beat_d   = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = pick_idx;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (transfer) begin
                    beat_d = beat_cnt + 1'b1;
                end
                if (rel) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    beat_d   = '0;
                    rr_ptr_d = IDX_W'(rr_next(int'(grant_id), N_REQ));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            grant_id <= grant_d;
            beat_cnt <= beat_d;
        end
    end

endmodule
